cpu_scoreboard: RTL and testbench
=================================

# cpu_scoreboard

Parametrised hazard scoreboard for the in-order CPU pipeline, sitting beside decode and driving the IF/ID and ID/EX pipe-register enables. It generalises the stateless stall detector in three ways:
- Per-register countdowns replace compare-against-every-stage logic.
- Register count, writeback latency and jump/branch shadow length are parameters.
- An optional register-file write-through bypass mode shortens dependent stalls.

It also adds a pipeline hold input and a saturating stall-cycle performance counter.

## Interface
- NUM_REGS, 16, number of architectural registers.
- SEL_W, 4, register select width; NUM_REGS <= 2**SEL_W.
- WB_LAT, 4, edges from issue acceptance to RF write commit; 1..15.
- JB_LAT, 3, edges of fetch shadow after an accepted jump/branch; 0..15.
- RF_BYPASS, 0, 1 = RF write-through, register readable in its commit cycle.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  decode holds a valid instruction.
- iss_src1 / iss_src2  in  SEL_W  source registers.
- iss_src1_en / iss_src2_en  in  1  source is actually read.
- iss_dst  in  SEL_W  destination register.
- iss_dst_en  in  1  instruction writes the RF.
- iss_jb  in  1  instruction is a jump/branch.
- hold  in  1  whole-pipeline freeze (e.g. memory wait).
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.
- stall  out  1  combinational: decode must not advance.
- issue  out  1  combinational: instruction accepted this cycle.
- busy_vec  out  NUM_REGS  registered per-register pending-write flags.
- jb_busy  out  1  jump/branch shadow active.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- State:
  - cnt[r], width 4, one per register.
  - jb_cnt, width 4.
  - stall_cnt.
- busy(r):
  - RF_BYPASS=0: cnt[r] != 0.
  - RF_BYPASS=1: cnt[r] > 1.
- raw = (iss_src1_en & busy(iss_src1)) | (iss_src2_en & busy(iss_src2)).
- stall = iss_valid & (raw | jb_busy).
- issue = iss_valid & ~stall & ~hold.
- On an edge with hold=0:
  - Every nonzero cnt[r] decrements by 1.
  - Nonzero jb_cnt decrements by 1.
- On an edge with issue=1:
  - iss_dst_en sets cnt[iss_dst] = WB_LAT. The set overrides the decrement of the same entry.
  - iss_jb sets jb_cnt = JB_LAT. With JB_LAT=0 there is no shadow.
- On an edge with hold=1: all cnt and jb_cnt are frozen.
- Destination-only conflicts (WAW) do not stall. In-order fixed latency guarantees ordering, and the later set simply reloads the counter.
- Select values >= NUM_REGS are treated as never busy and are ignored as destinations.
- busy_vec[r] = (cnt[r] != 0), independent of RF_BYPASS.
- jb_busy = (jb_cnt != 0).
- stall_cnt:
  - Increments on each edge where stall=1 & hold=0.
  - Saturates at all-ones.
  - stall_cnt_clr has priority and zeroes it.

## Timing
- Reset (async, rst_n=0): all cnt=0, jb_cnt=0, stall_cnt=0.
  - busy_vec=0, jb_busy=0.
  - stall=0 and issue=iss_valid & ~hold.
- Reset mid-operation discards all pending writes and shadows immediately. There is no recovery state.
- stall and issue are same-cycle combinational from inputs and state; there is no registered latency on the handshake.
- Producer accepted at edge k:
  - RF_BYPASS=0: a dependent instruction issues no earlier than the cycle after edge k+WB_LAT (WB_LAT stall cycles with no hold).
  - RF_BYPASS=1: one cycle earlier.
- Each hold cycle extends these windows by one cycle.
- A jump/branch accepted at edge k stalls any valid instruction for JB_LAT cycles. The next issue is possible in the cycle after edge k+JB_LAT.
- Simultaneous events:
  - Issue on the same edge a counter reaches 0 reloads it to WB_LAT.
  - stall_cnt_clr together with an increment condition yields 0.

## Test plan
- Reset → busy_vec=16'h0, jb_busy=0, stall_cnt=0; with iss_valid=1 and no hazards, issue=1.
- Issue write r3 (WB_LAT=4, RF_BYPASS=0), then an instruction reading r3 as src1 → stall=1 for exactly 4 cycles, issue=1 in the 5th; stall_cnt=4; busy_vec[3] high for 4 cycles.
- Same sequence with RF_BYPASS=1 → stall for 3 cycles; busy_vec[3] still high for 4.
- Issue write r5, hold=1 for 2 cycles during the countdown, dependent instruction waiting → 6 stall cycles; stall_cnt counts only the 4 non-hold cycles.
- Accept iss_jb with JB_LAT=3, next instruction independent → stall=1 for 3 cycles; jb_busy falls after edge 3.
- CNT_W=4: hold stall for 20 cycles → stall_cnt saturates at 4'hF; assert stall_cnt_clr → 0. Pulse rst_n low mid-countdown → busy_vec=0 asynchronously.

Source files
------------

// File: rtl/cpu_scoreboard.sv
// cpu_scoreboard
//   Hazard scoreboard for the in-order pipeline. Sits beside decode and
//   decides each cycle whether the instruction in decode may advance.
//   A 4-bit countdown per architectural register tracks the edges left
//   until its pending write commits. A separate countdown covers the fetch
//   shadow after a jump/branch. A saturating counter records stall cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   iss_valid             decode holds a valid instruction
//   iss_src1/2, *_en      source register selects and read enables
//   iss_dst, iss_dst_en   destination select and RF write enable
//   iss_jb                instruction is a jump/branch
//   hold                  whole-pipeline freeze
//   stall_cnt_clr         synchronous clear of stall_cnt
//   stall                 decode must not advance (combinational)
//   issue                 instruction accepted this cycle (combinational)
//   busy_vec              per-register pending-write flags (registered)
//   jb_busy               jump/branch shadow active
//   stall_cnt             saturating count of stalled, non-hold cycles
module cpu_scoreboard #(
   parameter int NUM_REGS  = 16,
   parameter int SEL_W     = 4,
   parameter int WB_LAT    = 4,
   parameter int JB_LAT    = 3,
   parameter int RF_BYPASS = 0,
   parameter int CNT_W     = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                iss_valid,
   input  logic [SEL_W-1:0]    iss_src1,
   input  logic [SEL_W-1:0]    iss_src2,
   input  logic                iss_src1_en,
   input  logic                iss_src2_en,
   input  logic [SEL_W-1:0]    iss_dst,
   input  logic                iss_dst_en,
   input  logic                iss_jb,
   input  logic                hold,
   input  logic                stall_cnt_clr,
   output logic                stall,
   output logic                issue,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                jb_busy,
   output logic [CNT_W-1:0]    stall_cnt
);

   logic [3:0]          cnt [NUM_REGS];
   logic [3:0]          jb_cnt;
   logic [NUM_REGS-1:0] reg_busy;
   logic                src1_busy;
   logic                src2_busy;
   logic                raw;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // With write-through the register is readable in the cycle its count is 1,
   // so only counts above 1 block a reader.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_vec[r] = (cnt[r] != 4'd0);
         reg_busy[r] = (RF_BYPASS != 0) ? (cnt[r] > 4'd1) : (cnt[r] != 4'd0);
      end
   end

   // Selects at or above NUM_REGS match no entry and so never report busy.
   always_comb begin
      src1_busy = 1'b0;
      src2_busy = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (iss_src1 == SEL_W'(r)) src1_busy = reg_busy[r];
         if (iss_src2 == SEL_W'(r)) src2_busy = reg_busy[r];
      end
   end

   assign jb_busy = (jb_cnt != 4'd0);
   assign raw     = (iss_src1_en & src1_busy) | (iss_src2_en & src2_busy);
   assign stall   = iss_valid & (raw | jb_busy);
   assign issue   = iss_valid & ~stall & ~hold;

   // Countdowns advance only on non-hold edges. issue already implies
   // ~hold, so a reload always wins over the decrement of the same entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= 4'd0;
         jb_cnt    <= 4'd0;
         stall_cnt <= '0;
      end else begin
         if (!hold) begin
            for (int r = 0; r < NUM_REGS; r++) begin
               if (issue && iss_dst_en && (iss_dst == SEL_W'(r)))
                  cnt[r] <= 4'(WB_LAT);
               else if (cnt[r] != 4'd0)
                  cnt[r] <= cnt[r] - 4'd1;
            end
            if (issue && iss_jb)
               jb_cnt <= 4'(JB_LAT);
            else if (jb_cnt != 4'd0)
               jb_cnt <= jb_cnt - 4'd1;
         end
         if (stall_cnt_clr)
            stall_cnt <= '0;
         else if (stall && !hold)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Self-checking bench for cpu_scoreboard. Two instances share the inputs:
//   dut A: 16 regs, no bypass, 4-bit stall counter
//   dut B: 12 regs (selects 12..15 out of range), bypass, 32-bit counter
// The reference model is timestamp based: it counts non-hold edges and stores,
// per register, the edge index at which the pending write commits.
module tb_cpu_scoreboard;

   localparam int WB = 4;
   localparam int JB = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        iss_valid = 0, iss_src1_en = 0, iss_src2_en = 0;
   logic        iss_dst_en = 0, iss_jb = 0, hold = 0, stall_cnt_clr = 0;
   logic [3:0]  iss_src1 = 0, iss_src2 = 0, iss_dst = 0;

   logic        stall_a, issue_a, jb_busy_a;
   logic [15:0] busy_vec_a;
   logic [3:0]  stall_cnt_a;
   logic        stall_b, issue_b, jb_busy_b;
   logic [11:0] busy_vec_b;
   logic [31:0] stall_cnt_b;

   int checks = 0;
   int errors = 0;

   longint adv [2];
   longint commit [2][16];
   longint jb_end [2];
   longint scnt [2];
   int     nregs [2] = '{16, 12};
   int     byp   [2] = '{0, 1};
   longint cmax  [2] = '{15, 64'hFFFF_FFFF};
   bit     e_stall [2];
   bit     e_issue [2];
   bit     obs_stall [2];

   always #5 clk = ~clk;

   cpu_scoreboard #(.NUM_REGS(16), .SEL_W(4), .WB_LAT(WB), .JB_LAT(JB),
                    .RF_BYPASS(0), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid),
      .iss_src1(iss_src1), .iss_src2(iss_src2),
      .iss_src1_en(iss_src1_en), .iss_src2_en(iss_src2_en),
      .iss_dst(iss_dst), .iss_dst_en(iss_dst_en), .iss_jb(iss_jb),
      .hold(hold), .stall_cnt_clr(stall_cnt_clr),
      .stall(stall_a), .issue(issue_a), .busy_vec(busy_vec_a),
      .jb_busy(jb_busy_a), .stall_cnt(stall_cnt_a));

   cpu_scoreboard #(.NUM_REGS(12), .SEL_W(4), .WB_LAT(WB), .JB_LAT(JB),
                    .RF_BYPASS(1), .CNT_W(32)) dut_b (
      .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid),
      .iss_src1(iss_src1), .iss_src2(iss_src2),
      .iss_src1_en(iss_src1_en), .iss_src2_en(iss_src2_en),
      .iss_dst(iss_dst), .iss_dst_en(iss_dst_en), .iss_jb(iss_jb),
      .hold(hold), .stall_cnt_clr(stall_cnt_clr),
      .stall(stall_b), .issue(issue_b), .busy_vec(busy_vec_b),
      .jb_busy(jb_busy_b), .stall_cnt(stall_cnt_b));

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_busy(input int i, input int sel);
      if (sel >= nregs[i]) return 1'b0;
      if (byp[i] != 0) return (commit[i][sel] - adv[i]) > 1;
      return commit[i][sel] > adv[i];
   endfunction

   function automatic longint m_busy_vec(input int i);
      longint v = 0;
      for (int r = 0; r < nregs[i]; r++)
         if (commit[i][r] > adv[i]) v |= (64'd1 << r);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         adv[i] = 0; jb_end[i] = 0; scnt[i] = 0;
         for (int r = 0; r < 16; r++) commit[i][r] = 0;
      end
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_busy_a", busy_vec_a, 0);
      chk("rst_busy_b", busy_vec_b, 0);
      chk("rst_jb_a", jb_busy_a, 0);
      chk("rst_jb_b", jb_busy_b, 0);
      chk("rst_cnt_a", stall_cnt_a, 0);
      chk("rst_cnt_b", stall_cnt_b, 0);
      chk("rst_stall_a", stall_a, 0);
      chk("rst_issue_a", issue_a, iss_valid & ~hold);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Inputs are already driven; check this cycle, then advance the model.
   task automatic tick();
      bit raw, jbb;
      #1;
      for (int i = 0; i < 2; i++) begin
         raw = (iss_src1_en && m_busy(i, int'(iss_src1))) ||
               (iss_src2_en && m_busy(i, int'(iss_src2)));
         jbb = jb_end[i] > adv[i];
         e_stall[i] = iss_valid && (raw || jbb);
         e_issue[i] = iss_valid && !e_stall[i] && !hold;
      end
      obs_stall[0] = stall_a;
      obs_stall[1] = stall_b;
      chk("stall_a", stall_a, e_stall[0]);
      chk("issue_a", issue_a, e_issue[0]);
      chk("busy_vec_a", busy_vec_a, m_busy_vec(0));
      chk("jb_busy_a", jb_busy_a, jb_end[0] > adv[0]);
      chk("stall_cnt_a", stall_cnt_a, scnt[0]);
      chk("stall_b", stall_b, e_stall[1]);
      chk("issue_b", issue_b, e_issue[1]);
      chk("busy_vec_b", busy_vec_b, m_busy_vec(1));
      chk("jb_busy_b", jb_busy_b, jb_end[1] > adv[1]);
      chk("stall_cnt_b", stall_cnt_b, scnt[1]);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (stall_cnt_clr) scnt[i] = 0;
         else if (e_stall[i] && !hold) scnt[i] = (scnt[i] + 1 > cmax[i]) ? cmax[i] : scnt[i] + 1;
         if (!hold) begin
            adv[i]++;
            if (e_issue[i] && iss_dst_en && int'(iss_dst) < nregs[i])
               commit[i][iss_dst] = adv[i] + WB;
            if (e_issue[i] && iss_jb) jb_end[i] = adv[i] + JB;
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input int s1, input bit s1e, input int d,
                        input bit de, input bit jb, input bit h);
      iss_valid = v; iss_src1 = 4'(s1); iss_src1_en = s1e;
      iss_src2 = 4'd0; iss_src2_en = 1'b0;
      iss_dst = 4'(d); iss_dst_en = de; iss_jb = jb; hold = h;
      stall_cnt_clr = 1'b0;
   endtask

   initial begin
      int na, nb, nbusy;

      // reset with a hazard-free valid instruction waiting
      drive(1, 0, 0, 0, 0, 0, 0);
      do_reset();

      // RAW on r3, no hold
      drive(1, 0, 0, 3, 1, 0, 0); tick();
      drive(1, 3, 1, 0, 0, 0, 0);
      na = 0; nb = 0; nbusy = 0;
      repeat (6) begin
         tick();
         na += int'(obs_stall[0]); nb += int'(obs_stall[1]);
      end
      chk("raw_stalls_a", na, 4);
      chk("raw_stalls_b", nb, 3);
      chk("raw_cnt_a", stall_cnt_a, 4);
      chk("raw_cnt_b", stall_cnt_b, 3);

      // busy_vec[3] lifetime
      do_reset();
      drive(1, 0, 0, 3, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (6) begin
         #1; nbusy += int'(busy_vec_a[3]) + int'(busy_vec_b[3]);
         tick();
      end
      chk("busy3_cycles", nbusy, 8);

      // RAW on r5 with two hold cycles in the countdown
      do_reset();
      drive(1, 0, 0, 5, 1, 0, 0); tick();
      na = 0; nb = 0;
      for (int c = 0; c < 8; c++) begin
         drive(1, 5, 1, 0, 0, 0, (c == 1 || c == 2));
         tick();
         na += int'(obs_stall[0]); nb += int'(obs_stall[1]);
      end
      chk("hold_stalls_a", na, 6);
      chk("hold_stalls_b", nb, 5);
      chk("hold_cnt_a", stall_cnt_a, 4);
      chk("hold_cnt_b", stall_cnt_b, 3);

      // jump/branch shadow
      do_reset();
      drive(1, 0, 0, 0, 0, 1, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0);
      na = 0; nb = 0; nbusy = 0;
      repeat (5) begin
         #1; nbusy += int'(jb_busy_a);
         tick();
         na += int'(obs_stall[0]); nb += int'(obs_stall[1]);
      end
      chk("jb_stalls_a", na, 3);
      chk("jb_stalls_b", nb, 3);
      chk("jb_busy_cycles", nbusy, 3);

      // saturate the 4-bit counter, clear it while a stall is counting
      do_reset();
      drive(1, 1, 1, 1, 1, 0, 0);
      repeat (30) tick();
      chk("sat_cnt_a", stall_cnt_a, 4'hF);
      drive(1, 1, 1, 1, 1, 0, 0);
      stall_cnt_clr = 1'b1; tick();
      chk("clr_cnt_a", stall_cnt_a, 0);
      chk("clr_cnt_b", stall_cnt_b, 0);

      // reset in the middle of a countdown
      drive(1, 0, 0, 7, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0); tick();
      do_reset();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         iss_valid     = ($urandom_range(3) != 0);
         iss_src1      = 4'($urandom_range(15));
         iss_src2      = 4'($urandom_range(15));
         iss_src1_en   = 1'($urandom_range(1));
         iss_src2_en   = 1'($urandom_range(1));
         iss_dst       = 4'($urandom_range(15));
         iss_dst_en    = 1'($urandom_range(1));
         iss_jb        = ($urandom_range(7) == 0);
         hold          = ($urandom_range(5) == 0);
         stall_cnt_clr = ($urandom_range(31) == 0);
         if ($urandom_range(99) == 0) do_reset();
         else tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
